// File: rtl/sample_assembler_pkg.sv
// sample_assembler_pkg: shared widths, channel index sizing and FSM state types
package sample_assembler_pkg;
  localparam int RAW_WIDTH = 16;
  localparam int INPUT_CHANNELS = 4;
  localparam int MODE_WIDTH = 2;
  localparam int LABEL_WIDTH = 5;
  function automatic int ceil_log2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction
  localparam int CHAN_IDX_WIDTH = ceil_log2(INPUT_CHANNELS);
  typedef enum logic {ASSEMBLE = 1'b0, HOLD_LAST = 1'b1} asm_state_e;
  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} out_state_e;
endpackage

// File: rtl/sample_assembler_if.sv
// sample_assembler_if: serial sample input and parallel frame output of the assembler
interface sample_assembler_if
  import sample_assembler_pkg::*;
#(
  parameter int RAW_W   = RAW_WIDTH,
  parameter int CHANS   = INPUT_CHANNELS,
  parameter int MODE_W  = MODE_WIDTH,
  parameter int LABEL_W = LABEL_WIDTH,
  parameter int IDX_W   = CHAN_IDX_WIDTH
) ();
  logic                   SampleValid_SI;
  logic [IDX_W-1:0]       SampleChan_DI;
  logic [RAW_W-1:0]       Sample_DI;
  logic [MODE_W-1:0]      ModeIn_SI;
  logic [LABEL_W-1:0]     LabelIn_DI;
  logic                   SampleReady_SO;
  logic                   ValidOut_SO;
  logic                   ReadyIn_SI;
  logic [RAW_W*CHANS-1:0] Raw_DO;
  logic [MODE_W-1:0]      ModeOut_SO;
  logic [LABEL_W-1:0]     LabelOut_DO;
  logic                   Error_SO;
  logic [7:0]             DropCnt_DO;
  modport master (
    output SampleValid_SI, SampleChan_DI, Sample_DI, ModeIn_SI, LabelIn_DI, ReadyIn_SI,
    input  SampleReady_SO, ValidOut_SO, Raw_DO, ModeOut_SO, LabelOut_DO, Error_SO, DropCnt_DO
  );
  modport slave (
    input  SampleValid_SI, SampleChan_DI, Sample_DI, ModeIn_SI, LabelIn_DI, ReadyIn_SI,
    output SampleReady_SO, ValidOut_SO, Raw_DO, ModeOut_SO, LabelOut_DO, Error_SO, DropCnt_DO
  );
endinterface

// File: rtl/sample_assembler_sat_counter.sv
// sample_assembler_sat_counter: 8-bit incrementer that sticks at 255
module sample_assembler_sat_counter (
  input  logic       Clk_CI,
  input  logic       Reset_RI,
  input  logic       Inc_SI,
  output logic [7:0] Cnt_DO
);
  logic [7:0] cnt_q;
  // count up on each increment request until all ones
  always_ff @(posedge Clk_CI or posedge Reset_RI)
    if (Reset_RI) cnt_q <= '0;
    else if (Inc_SI && cnt_q != 8'hFF) cnt_q <= cnt_q + 8'd1;
  assign Cnt_DO = cnt_q;
endmodule

// File: rtl/sample_assembler.sv
// sample_assembler: gathers in-order serial channel samples into a frame held for the encoder
module sample_assembler
  import sample_assembler_pkg::*;
(
  input logic Clk_CI,
  input logic Reset_RI,
  sample_assembler_if.slave bus
);
  localparam logic [CHAN_IDX_WIDTH-1:0] LAST = CHAN_IDX_WIDTH'(INPUT_CHANNELS - 1);
  logic [RAW_WIDTH-1:0] slot_q [INPUT_CHANNELS];
  logic [CHAN_IDX_WIDTH-1:0] exp_q, exp_d;
  asm_state_e asm_q, asm_d;
  out_state_e out_q, out_d;
  logic [RAW_WIDTH*INPUT_CHANNELS-1:0] raw_q, frame_d;
  logic [MODE_WIDTH-1:0] mode_q, mode_asm_q;
  logic [LABEL_WIDTH-1:0] label_q, label_asm_q;
  logic err_q, xfer, match, cap0, last_acc, out_xfer, drop;
  assign bus.SampleReady_SO = !((exp_q == LAST && out_q == FULL) || asm_q == HOLD_LAST);
  assign xfer     = bus.SampleValid_SI && bus.SampleReady_SO;
  assign match    = bus.SampleChan_DI == exp_q;
  assign cap0     = xfer && bus.SampleChan_DI == '0;
  assign last_acc = xfer && match && exp_q == LAST;
  assign out_xfer = out_q == FULL && bus.ReadyIn_SI;
  assign drop     = xfer && !match;
  // next channel expectation and the two small FSMs
  always_comb begin
    exp_d = !xfer ? exp_q : match ? ((exp_q == LAST) ? '0 : exp_q + CHAN_IDX_WIDTH'(1))
          : (cap0 ? CHAN_IDX_WIDTH'(1) : '0);
    out_d = last_acc ? FULL : out_xfer ? EMPTY : out_q;
    asm_d = (asm_q == ASSEMBLE) ? ((exp_q == LAST && out_q == FULL && !bus.ReadyIn_SI) ? HOLD_LAST : ASSEMBLE)
          : (out_xfer ? ASSEMBLE : HOLD_LAST);
  end
  // frame image: stored channels below the last one plus the sample arriving now
  always_comb begin
    frame_d = '0;
    for (int j = 0; j < INPUT_CHANNELS; j++)
      frame_d[j*RAW_WIDTH +: RAW_WIDTH] = (j == INPUT_CHANNELS - 1) ? bus.Sample_DI : slot_q[j];
  end
  // assembly slots, captured header fields and the registered output frame
  always_ff @(posedge Clk_CI or posedge Reset_RI)
    if (Reset_RI) begin
      exp_q       <= '0;
      asm_q       <= ASSEMBLE;
      out_q       <= EMPTY;
      raw_q       <= '0;
      mode_q      <= '0;
      label_q     <= '0;
      mode_asm_q  <= '0;
      label_asm_q <= '0;
      err_q       <= 1'b0;
      for (int j = 0; j < INPUT_CHANNELS; j++) slot_q[j] <= '0;
    end else begin
      exp_q <= exp_d;
      asm_q <= asm_d;
      out_q <= out_d;
      err_q <= err_q | drop;
      if (xfer && (match || cap0)) slot_q[bus.SampleChan_DI] <= bus.Sample_DI;
      if (cap0) begin
        mode_asm_q  <= bus.ModeIn_SI;
        label_asm_q <= bus.LabelIn_DI;
      end
      if (last_acc) begin
        raw_q   <= frame_d;
        mode_q  <= mode_asm_q;
        label_q <= label_asm_q;
      end
    end
  sample_assembler_sat_counter u_drop (
    .Clk_CI  (Clk_CI),
    .Reset_RI(Reset_RI),
    .Inc_SI  (drop),
    .Cnt_DO  (bus.DropCnt_DO)
  );
  assign bus.ValidOut_SO = out_q == FULL;
  assign bus.Raw_DO      = raw_q;
  assign bus.ModeOut_SO  = mode_q;
  assign bus.LabelOut_DO = label_q;
  assign bus.Error_SO    = err_q;
endmodule

// File: tb/tb_sample_assembler.sv
// tb_sample_assembler: randomized and directed scoreboard bench for sample_assembler
module tb_sample_assembler;
  import sample_assembler_pkg::*;
  localparam int N = INPUT_CHANNELS;
  localparam int W = RAW_WIDTH;
  typedef struct {
    logic [W*N-1:0] raw;
    logic [MODE_WIDTH-1:0] mode;
    logic [LABEL_WIDTH-1:0] label;
  } frame_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  sample_assembler_if bus ();
  sample_assembler dut (.Clk_CI(clk), .Reset_RI(rst), .bus(bus));
  int checks = 0, failures = 0;
  frame_t exq[$];
  logic [W-1:0] part[$];
  logic [MODE_WIDTH-1:0] pm = '0;
  logic [LABEL_WIDTH-1:0] pl = '0;
  int drops = 0;
  bit err = 1'b0;
  int rdy_mode = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // reference: a frame is the in-order run of channels 0..N-1; anything else breaks it
  task automatic model_xfer(input int chan, input logic [W-1:0] s, input logic [MODE_WIDTH-1:0] m,
                            input logic [LABEL_WIDTH-1:0] l);
    frame_t f;
    if (chan == part.size()) begin
      if (chan == 0) begin pm = m; pl = l; end
      part.push_back(s);
      if (part.size() == N) begin
        for (int j = 0; j < N; j++) f.raw[j*W +: W] = part[j];
        f.mode = pm;
        f.label = pl;
        exq.push_back(f);
        part.delete();
      end
    end else begin
      if (drops < 255) drops++;
      err = 1'b1;
      part.delete();
      if (chan == 0) begin part.push_back(s); pm = m; pl = l; end
    end
  endtask

  // called at posedge+2; returns at posedge+2 with valid low
  task automatic send(input int chan, input logic [W-1:0] s, input logic [MODE_WIDTH-1:0] m,
                      input logic [LABEL_WIDTH-1:0] l);
    int waited = 0;
    bus.SampleValid_SI = 1'b1;
    bus.SampleChan_DI = CHAN_IDX_WIDTH'(chan);
    bus.Sample_DI = s;
    bus.ModeIn_SI = m;
    bus.LabelIn_DI = l;
    forever begin
      chk("sample_ready", bus.SampleReady_SO, !(part.size() == N - 1 && exq.size() != 0));
      if (bus.SampleReady_SO) break;
      if (++waited > 200) begin
        failures++;
        $display("FAIL stall_timeout actual=stalled required=accept chan=%0d", chan);
        break;
      end
      @(posedge clk); #2;
    end
    if (bus.SampleReady_SO) begin
      @(posedge clk);
      model_xfer(chan, s, m, l);
      #2;
    end
    bus.SampleValid_SI = 1'b0;
  endtask

  task automatic send_frame(input logic [W-1:0] base, input logic [MODE_WIDTH-1:0] m,
                            input logic [LABEL_WIDTH-1:0] l);
    for (int c = 0; c < N; c++) send(c, base + W'(c), m, l);
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #2; end
  endtask

  task automatic do_reset();
    @(posedge clk); #3;
    rst = 1'b1;
    bus.SampleValid_SI = 1'b0;
    #1;
    chk("rst_valid", bus.ValidOut_SO, 0);
    chk("rst_raw", bus.Raw_DO, 0);
    chk("rst_mode", bus.ModeOut_SO, 0);
    chk("rst_label", bus.LabelOut_DO, 0);
    chk("rst_error", bus.Error_SO, 0);
    chk("rst_drop", bus.DropCnt_DO, 0);
    chk("rst_ready", bus.SampleReady_SO, 1);
    exq.delete();
    part.delete();
    drops = 0;
    err = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
  endtask

  // encoder-side ready: always, never, or random
  initial forever begin
    @(posedge clk); #2;
    bus.ReadyIn_SI = (rdy_mode == 0) ? 1'b1 : (rdy_mode == 1) ? 1'b0 : ($urandom_range(0, 2) != 0);
  end

  // monitor: compares presented frame and status against the scoreboard between edges
  initial forever begin
    @(negedge clk);
    if (!rst) begin
      chk("valid_out", bus.ValidOut_SO, exq.size() != 0);
      chk("error", bus.Error_SO, err);
      chk("drop_cnt", bus.DropCnt_DO, drops);
      if (bus.ValidOut_SO && exq.size() != 0) begin
        chk("raw", bus.Raw_DO, exq[0].raw);
        chk("mode", bus.ModeOut_SO, exq[0].mode);
        chk("label", bus.LabelOut_DO, exq[0].label);
        if (bus.ReadyIn_SI) void'(exq.pop_front());
      end
    end
  end

  initial begin
    bus.SampleValid_SI = 1'b0;
    bus.SampleChan_DI = '0;
    bus.Sample_DI = '0;
    bus.ModeIn_SI = '0;
    bus.LabelIn_DI = '0;
    bus.ReadyIn_SI = 1'b0;
    do_reset();
    // normal frame
    rdy_mode = 0;
    send(0, 16'h0011, 2'd1, 5'd3);
    send(1, 16'h0022, 2'd0, 5'd0);
    send(2, 16'h0033, 2'd0, 5'd0);
    send(3, 16'h0044, 2'd0, 5'd0);
    chk("normal_valid", bus.ValidOut_SO, 1);
    chk("normal_raw", bus.Raw_DO, 64'h0044_0033_0022_0011);
    chk("normal_mode", bus.ModeOut_SO, 1);
    chk("normal_label", bus.LabelOut_DO, 3);
    idle(2);
    // backpressure
    rdy_mode = 1;
    idle(1);
    send_frame(16'h1000, 2'd2, 5'd7);
    for (int c = 0; c < N - 1; c++) send(c, 16'h2000 + 16'(c), 2'd3, 5'd9);
    chk("bp_ready_low", bus.SampleReady_SO, 0);
    fork begin repeat (4) @(posedge clk); rdy_mode = 0; end join_none
    send(N - 1, 16'h2003, 2'd0, 5'd0);
    idle(3);
    // misalignment back to channel 0
    send(0, 16'h3000, 2'd1, 5'd1);
    send(1, 16'h3001, 2'd1, 5'd1);
    send(0, 16'h4000, 2'd2, 5'd4);
    chk("mis0_error", bus.Error_SO, 1);
    chk("mis0_drop", bus.DropCnt_DO, 1);
    for (int c = 1; c < N; c++) send(c, 16'h4000 + 16'(c), 2'd0, 5'd0);
    idle(2);
    // stray channel with nothing in progress, repeated to saturate the drop count
    repeat (300) begin
      send(2, 16'hDEAD, 2'd0, 5'd0);
      send_frame(16'($urandom), 2'($urandom), 5'($urandom));
    end
    idle(2);
    chk("drop_sat", bus.DropCnt_DO, 255);
    // reset with a pending output frame and a partial frame
    rdy_mode = 1;
    idle(1);
    send_frame(16'h5000, 2'd1, 5'd2);
    send(0, 16'h6000, 2'd1, 5'd1);
    send(1, 16'h6001, 2'd1, 5'd1);
    do_reset();
    rdy_mode = 0;
    send_frame(16'h7000, 2'd3, 5'd31);
    idle(3);
    chk("post_rst_drop", bus.DropCnt_DO, 0);
    chk("post_rst_error", bus.Error_SO, 0);
    // randomized traffic
    rdy_mode = 2;
    repeat (1500) begin
      int c;
      c = ($urandom_range(0, 9) < 8) ? (part.size() % N) : int'($urandom_range(0, N - 1));
      if ($urandom_range(0, 3) == 0) idle(1);
      send(c, 16'($urandom), 2'($urandom), 5'($urandom));
    end
    rdy_mode = 0;
    idle(5);
    chk("drain", exq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
